// File: rtl/usb_xact_ctrl.sv
// usb_xact_ctrl: USB device transaction controller.
// Sequences token -> data -> handshake per endpoint and keeps the
// per-endpoint DATA0/DATA1 toggle bits. All outputs are registered.
// Optional build macro USB_XACT_TIMEOUT_EN adds a turnaround timeout in
// RX_DATA / WAIT_ACK; without it those states wait indefinitely.
module usb_xact_ctrl #(
  parameter int         NUM_EP  = 4,
  parameter logic [7:0] TIMEOUT = 8'd200
) (
  input  logic       clk,
  input  logic       rst_n,
  input  logic       rx_pid_en,
  input  logic [3:0] rx_pid,
  input  logic [3:0] rx_endp,
  input  logic       crc5_err,
  input  logic       rx_data_done,
  input  logic       rx_data_err,
  input  logic       rx_data_tog,
  input  logic       ep_rx_ready,
  input  logic       ep_tx_ready,
  input  logic       ep_stall,
  output logic       rx_handshake_on,
  output logic       tx_data_start,
  output logic       tx_data_tog,
  input  logic       tx_data_done,
  output logic       tx_hs_en,
  output logic [3:0] tx_hs_pid,
  output logic [3:0] xact_endp,
  output logic       xact_done,
  output logic       xact_ok
);
  localparam logic [3:0] PID_OUT   = 4'b0001;
  localparam logic [3:0] PID_IN    = 4'b1001;
  localparam logic [3:0] PID_SETUP = 4'b1101;
  localparam logic [3:0] PID_ACK   = 4'b0010;
  localparam logic [3:0] PID_NAK   = 4'b1010;
  localparam logic [3:0] PID_STALL = 4'b1110;
  localparam logic [4:0] NUM_EP_W  = 5'(NUM_EP);

  typedef enum logic [2:0] {IDLE, RX_DATA, TX_DATA, WAIT_ACK, TX_HS} state_t;

  state_t      state_q, state_d;
  logic        setup_q, setup_d;
  logic        ok_pend_q, ok_pend_d;   // result reported when TX_HS finishes
  // Sized for the full 4-bit endpoint space so rx_endp indexes it directly;
  // bits at or above NUM_EP are never written because such tokens are rejected.
  logic [15:0] tog_q, tog_d;
  logic [3:0]  endp_d, hs_pid_d;
  logic        data_tog_d;
  logic        done_ok;                // xact_ok value on the way back to IDLE
  logic        tok_ok, leave, timeout;

  assign tok_ok = rx_pid_en && !crc5_err && ({1'b0, rx_endp} < NUM_EP_W);
  assign leave  = (state_q != IDLE) && (state_d == IDLE);

`ifdef USB_XACT_TIMEOUT_EN
  logic [7:0] cnt_q;
  assign timeout = (cnt_q == TIMEOUT);

  // Turnaround counter: restarts on every state change, counts while waiting
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n)                                      cnt_q <= '0;
    else if (state_d != state_q)                     cnt_q <= '0;
    else if (state_q == RX_DATA || state_q == WAIT_ACK) cnt_q <= cnt_q + 8'd1;
  end
`else
  assign timeout = 1'b0;
`endif

  // Next-state, toggle bookkeeping and next values of registered outputs
  always_comb begin
    state_d    = state_q;
    setup_d    = setup_q;
    ok_pend_d  = ok_pend_q;
    tog_d      = tog_q;
    endp_d     = xact_endp;
    hs_pid_d   = tx_hs_pid;
    data_tog_d = tx_data_tog;
    done_ok    = 1'b0;
    case (state_q)
      IDLE: if (tok_ok) begin
        case (rx_pid)
          PID_OUT, PID_SETUP: begin
            state_d = RX_DATA;
            setup_d = (rx_pid == PID_SETUP);
            endp_d  = rx_endp;
          end
          PID_IN: begin
            endp_d    = rx_endp;
            ok_pend_d = 1'b0;
            if (ep_stall) begin
              state_d  = TX_HS;
              hs_pid_d = PID_STALL;
            end else if (!ep_tx_ready) begin
              state_d  = TX_HS;
              hs_pid_d = PID_NAK;
            end else begin
              state_d    = TX_DATA;
              data_tog_d = tog_q[rx_endp];
            end
          end
          default: ;
        endcase
      end
      RX_DATA: begin
        if (rx_data_done) begin
          if (rx_data_err) begin
            state_d = IDLE;
          end else begin
            state_d   = TX_HS;
            hs_pid_d  = PID_ACK;
            ok_pend_d = 1'b0;
            if (setup_q) begin
              tog_d[xact_endp] = 1'b1;
              ok_pend_d        = 1'b1;
            end else if (ep_stall) begin
              hs_pid_d = PID_STALL;
            end else if (!ep_rx_ready) begin
              hs_pid_d = PID_NAK;
            end else if (rx_data_tog == tog_q[xact_endp]) begin
              tog_d[xact_endp] = ~tog_q[xact_endp];
              ok_pend_d        = 1'b1;
            end
            // mismatched toggle: duplicate packet, ACK without committing
          end
        end else if (timeout) begin
          state_d = IDLE;
        end
      end
      TX_DATA: if (tx_data_done) state_d = WAIT_ACK;
      WAIT_ACK: begin
        if (rx_pid_en && !crc5_err) begin
          state_d = IDLE;
          if (rx_pid == PID_ACK) begin
            tog_d[xact_endp] = ~tog_q[xact_endp];
            done_ok          = 1'b1;
          end
        end else if (timeout) begin
          state_d = IDLE;
        end
      end
      TX_HS: begin
        state_d = IDLE;
        done_ok = ok_pend_q;
      end
      default: state_d = IDLE;
    endcase
  end

  // State, toggles and all registered outputs
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q         <= IDLE;
      setup_q         <= 1'b0;
      ok_pend_q       <= 1'b0;
      tog_q           <= '0;
      xact_endp       <= '0;
      tx_hs_pid       <= '0;
      tx_data_tog     <= 1'b0;
      tx_hs_en        <= 1'b0;
      tx_data_start   <= 1'b0;
      rx_handshake_on <= 1'b0;
      xact_done       <= 1'b0;
      xact_ok         <= 1'b0;
    end else begin
      state_q         <= state_d;
      setup_q         <= setup_d;
      ok_pend_q       <= ok_pend_d;
      tog_q           <= tog_d;
      xact_endp       <= endp_d;
      tx_hs_pid       <= hs_pid_d;
      tx_data_tog     <= data_tog_d;
      tx_hs_en        <= (state_d == TX_HS);
      tx_data_start   <= (state_d == TX_DATA) && (state_q != TX_DATA);
      rx_handshake_on <= (state_d == RX_DATA) || (state_d == WAIT_ACK);
      xact_done       <= leave;
      xact_ok         <= leave && done_ok;
    end
  end
endmodule
